mixer_duc_nco: RTL

Numerically controlled oscillator for the DUC mixer. It generates the 8-bit signed cosine/sine carrier pair that feeds the b operand of the mixer's 16s×8s→24 multipliers. A 24-bit phase accumulator drives a quarter-wave ROM through a 3-stage pipeline. Output uses a valid/ready handshake so the mixer can back-pressure it.

---
 rtl/mixer_duc_nco_if.sv | 40 ++++
 rtl/mixer_duc_nco.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mixer_duc_nco_if.sv
// -----------------------------------------------------------------------------
// mixer_duc_nco_if
// Control and sample-stream bundle for the DUC mixer carrier NCO.
//
//   enable   : request one new sample per pipeline advance
//   clr      : one-cycle pulse, phase accumulator <- 0
//   cfg_wr   : one-cycle pulse, latch fcw_in / poff_in
//   fcw_in   : frequency control word (unsigned, modulo 2^PHASE_W)
//   poff_in  : phase offset (unsigned, modulo 2^PHASE_W)
//   cos_out  : signed cosine sample
//   sin_out  : signed sine sample
//   m_valid  : cos_out/sin_out hold a sample
//   m_ready  : consumer takes the sample when m_valid && m_ready
//
// master = the mixer side (drives controls and m_ready, receives samples)
// slave  = the NCO itself
// -----------------------------------------------------------------------------
interface mixer_duc_nco_if #(
  parameter int PHASE_W = 24
);
  logic               enable;
  logic               clr;
  logic               cfg_wr;
  logic [PHASE_W-1:0] fcw_in;
  logic [PHASE_W-1:0] poff_in;
  logic signed [7:0]  cos_out;
  logic signed [7:0]  sin_out;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output enable, clr, cfg_wr, fcw_in, poff_in, m_ready,
    input  cos_out, sin_out, m_valid
  );

  modport slave (
    input  enable, clr, cfg_wr, fcw_in, poff_in, m_ready,
    output cos_out, sin_out, m_valid
  );
endinterface

// File: rtl/mixer_duc_nco.sv
// -----------------------------------------------------------------------------
// mixer_duc_nco
// Numerically controlled oscillator producing the 8-bit signed cos/sin carrier
// pair for the DUC mixer. A PHASE_W-bit accumulator feeds a quarter-wave sine
// ROM through a 3-stage pipeline; the output is a valid/ready stream that the
// mixer can back-pressure, and the whole pipeline freezes while it does.
//
// Ports:
//   ap_clk   : sole clock, rising edge
//   ap_rst_n : asynchronous, active-low reset
//   bus      : mixer_duc_nco_if.slave (enable, clr, cfg_wr, fcw_in, poff_in,
//              m_ready in; cos_out, sin_out, m_valid out)
//
// Parameters:
//   PHASE_W  : accumulator / frequency word / phase offset width (>= 10)
//   AMP      : ROM peak amplitude, must fit signed 8 bit
// -----------------------------------------------------------------------------
module mixer_duc_nco #(
  parameter int PHASE_W = 24,
  parameter int AMP     = 127
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  mixer_duc_nco_if.slave  bus
);

  localparam int  DATA_W = 8;
  localparam int  PH_W   = 10;   // ROM phase: 2 quadrant bits + 8 index bits
  localparam int  ROM_AW = 8;
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [DATA_W-1:0] AMP_Q   = DATA_W'(AMP);
  localparam logic [ROM_AW:0]          QUARTER = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [PH_W-1:0]          PH_QTR  = PH_W'(256);

  // Round a non-negative real to the nearest integer, halves upward.
  function automatic int round_half_up(input real v);
    return $rtoi(v + 0.5);
  endfunction

  // q(k) = round(AMP * sin(pi*k/512)); the Taylor series keeps the table an
  // elaboration-time constant without relying on tool math libraries.
  function automatic logic signed [DATA_W-1:0] quarter_sine(input int k);
    real x;
    real term;
    real sum;
    int  r;
    x    = PI * $itor(k) / 512.0;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ($itor(2 * n) * $itor(2 * n + 1));
      sum  = sum + term;
    end
    r = round_half_up($itor(AMP) * sum);
    return DATA_W'(r);
  endfunction

  // Odd quadrants walk the quarter wave backwards: address 256 - index.
  // Index 0 in an odd quadrant lands on the peak entry (address 256).
  function automatic logic [ROM_AW:0] mirror_addr(input logic [PH_W-1:0] ph);
    logic [ROM_AW:0] idx;
    idx = {1'b0, ph[ROM_AW-1:0]};
    return ph[ROM_AW] ? (QUARTER - idx) : idx;
  endfunction

  // Lower half-cycle is the negated quarter wave. Range is +-AMP, so the
  // negation can never overflow and no saturation is required.
  function automatic logic signed [DATA_W-1:0] apply_sign(
    input logic signed [DATA_W-1:0] v,
    input logic                     neg
  );
    return neg ? -v : v;
  endfunction

  // Entries 0..255; the k = 256 peak is handled by the address decode.
  logic signed [DATA_W-1:0] rom_tbl [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic signed [DATA_W-1:0] QV = quarter_sine(g);
    assign rom_tbl[g] = QV;
  end

  logic [PHASE_W-1:0]       acc;
  logic [PHASE_W-1:0]       fcw;
  logic [PHASE_W-1:0]       poff;
  logic                     adv;
  logic [PH_W-1:0]          ph_now;

  logic                     vld_p0;
  logic [PH_W-1:0]          ph_sin_p0;
  logic [PH_W-1:0]          ph_cos_p0;

  logic [ROM_AW:0]          addr_sin;
  logic [ROM_AW:0]          addr_cos;
  logic signed [DATA_W-1:0] rom_sin;
  logic signed [DATA_W-1:0] rom_cos;

  logic                     vld_p1;
  logic signed [DATA_W-1:0] mag_sin_p1;
  logic signed [DATA_W-1:0] mag_cos_p1;
  logic                     neg_sin_p1;
  logic                     neg_cos_p1;

  logic                     vld_p2;
  logic signed [DATA_W-1:0] sin_p2;
  logic signed [DATA_W-1:0] cos_p2;

  // Only a sample sitting unaccepted at the output can stall the pipe.
  assign adv = !(vld_p2 && !bus.m_ready);

  // Top PH_W bits of (acc + poff), wrapping modulo 2^PHASE_W.
  assign ph_now = PH_W'((acc + poff) >> (PHASE_W - PH_W));

  // Configuration and clr act on every edge, independent of back-pressure.
  // clr beats the accumulating step; the sample captured in that same cycle
  // still used the old acc.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc  <= '0;
      fcw  <= '0;
      poff <= '0;
    end else begin
      if (bus.cfg_wr) begin
        fcw  <= bus.fcw_in;
        poff <= bus.poff_in;
      end
      if (bus.clr) begin
        acc <= '0;
      end else if (adv && bus.enable) begin
        acc <= acc + fcw;
      end
    end
  end

  // ---- Stage p0: phase capture --------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p0 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= bus.enable;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (adv && bus.enable) begin
      ph_sin_p0 <= ph_now;
      ph_cos_p0 <= ph_now + PH_QTR;
    end
  end

  // ---- Stage p1: quarter-wave ROM read ------------------------------------
  always_comb begin
    addr_sin = mirror_addr(ph_sin_p0);
    addr_cos = mirror_addr(ph_cos_p0);
    rom_sin  = addr_sin[ROM_AW] ? AMP_Q : rom_tbl[addr_sin[ROM_AW-1:0]];
    rom_cos  = addr_cos[ROM_AW] ? AMP_Q : rom_tbl[addr_cos[ROM_AW-1:0]];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (adv && vld_p0) begin
      mag_sin_p1 <= rom_sin;
      mag_cos_p1 <= rom_cos;
      neg_sin_p1 <= ph_sin_p0[PH_W-1];
      neg_cos_p1 <= ph_cos_p0[PH_W-1];
    end
  end

  // ---- Stage p2: sign restore / output register ---------------------------
  // Output data is reset as well so the port reads 0 whenever reset is held.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p2 <= 1'b0;
      sin_p2 <= '0;
      cos_p2 <= '0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sin_p2 <= apply_sign(mag_sin_p1, neg_sin_p1);
        cos_p2 <= apply_sign(mag_cos_p1, neg_cos_p1);
      end
    end
  end

  assign bus.m_valid = vld_p2;
  assign bus.sin_out = sin_p2;
  assign bus.cos_out = cos_p2;

endmodule
